// File: rtl/maple_pkg.sv
// Shared Maple bus definitions: one-hot transmit state encoding, byte width and
// the XOR checksum accumulate helper reused by the receive path.
package maple_pkg;

  localparam int MAPLE_BYTE_W = 8;

  typedef enum logic [3:0] {
    ST_FILL  = 4'b0001,
    ST_SEND  = 4'b0010,
    ST_CKSUM = 4'b0100,
    ST_DRAIN = 4'b1000
  } maple_tx_state_e;

  function automatic logic [MAPLE_BYTE_W-1:0] maple_xor_acc(
    input logic [MAPLE_BYTE_W-1:0] acc,
    input logic [MAPLE_BYTE_W-1:0] b
  );
    return acc ^ b;
  endfunction

endpackage

// File: rtl/maple_byte_ram.sv
// DEPTH x 8 frame storage with one synchronous write port and an asynchronous
// read port so the head byte can be presented show-ahead.
module maple_byte_ram
  import maple_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [MAPLE_BYTE_W-1:0] wdata,
  input  logic [ADDR_W-1:0]       raddr,
  output logic [MAPLE_BYTE_W-1:0] rdata
);

  logic [MAPLE_BYTE_W-1:0] mem_r [DEPTH];

  // Write port; entries are only read back after being written in the same frame.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/maple_tx_frame_buffer.sv
// Maple transmit frame buffer: collects one frame, then feeds it byte by byte to the
// encoder. Define MAPLE_TX_CKSUM_EN to append the XOR checksum byte after the payload.
module maple_tx_frame_buffer
  import maple_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [MAPLE_BYTE_W-1:0] wr_data,
  input  logic                    wr_last,
  output logic                    wr_ready,
  output logic                    ovf,
  output logic                    tx_enable,
  input  logic                    next,
  output logic [MAPLE_BYTE_W-1:0] data,
  output logic                    empty,
  input  logic                    done,
  output logic                    busy
);

  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  maple_tx_state_e         state_r, state_s;
  logic [ADDR_W-1:0]       wr_ptr_r, rd_ptr_r;
  logic [ADDR_W:0]         count_r;
  logic                    drop_r, ovf_r, tx_enable_r;
  logic [MAPLE_BYTE_W-1:0] last_data_r, data_s, rd_data_s;
  logic                    empty_s, tx_en_s, store_s, pop_s, cap_s;
  logic                    drop_set_s, clear_s, ovf_s;
`ifdef MAPLE_TX_CKSUM_EN
  logic [MAPLE_BYTE_W-1:0] csum_r;
`endif

  maple_byte_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (store_s),
    .waddr (wr_ptr_r),
    .wdata (wr_data),
    .raddr (rd_ptr_r),
    .rdata (rd_data_s)
  );

  // Next-state logic and per-cycle datapath controls.
  always_comb begin
    state_s    = state_r;
    tx_en_s    = tx_enable_r;
    store_s    = 1'b0;
    pop_s      = 1'b0;
    cap_s      = 1'b0;
    drop_set_s = 1'b0;
    clear_s    = 1'b0;
    ovf_s      = 1'b0;
    case (state_r)
      ST_FILL: begin
        if (wr_en) begin
          if (count_r < CNT_FULL) begin
            store_s = 1'b1;
          end else begin
            drop_set_s = 1'b1;
          end
          // A closing byte that could not be stored also condemns the frame.
          if (wr_last) begin
            if (drop_r || (count_r == CNT_FULL)) begin
              clear_s = 1'b1;
              ovf_s   = 1'b1;
            end else begin
              state_s = ST_SEND;
              tx_en_s = 1'b1;
            end
          end else begin
            state_s = ST_FILL;
          end
        end else begin
          state_s = ST_FILL;
        end
      end
      ST_SEND: begin
        if (done) begin
          state_s = ST_FILL;
          tx_en_s = 1'b0;
          clear_s = 1'b1;
        end else if (next) begin
          pop_s = 1'b1;
          cap_s = 1'b1;
          if (count_r == CNT_ONE) begin
`ifdef MAPLE_TX_CKSUM_EN
            state_s = ST_CKSUM;
`else
            state_s = ST_DRAIN;
`endif
          end else begin
            state_s = ST_SEND;
          end
        end else begin
          state_s = ST_SEND;
        end
      end
`ifdef MAPLE_TX_CKSUM_EN
      ST_CKSUM: begin
        if (done) begin
          state_s = ST_FILL;
          tx_en_s = 1'b0;
          clear_s = 1'b1;
        end else if (next) begin
          cap_s   = 1'b1;
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_CKSUM;
        end
      end
`endif
      ST_DRAIN: begin
        if (done) begin
          state_s = ST_FILL;
          tx_en_s = 1'b0;
          clear_s = 1'b1;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_FILL;
        tx_en_s = 1'b0;
        clear_s = 1'b1;
      end
    endcase
  end

  // Show-ahead head byte; outside active sending the last presented byte is held.
  always_comb begin
    data_s  = last_data_r;
    empty_s = 1'b1;
    case (state_r)
      ST_SEND: begin
        data_s  = rd_data_s;
        empty_s = 1'b0;
      end
`ifdef MAPLE_TX_CKSUM_EN
      ST_CKSUM: begin
        data_s  = csum_r;
        empty_s = 1'b0;
      end
`endif
      default: begin
        data_s  = last_data_r;
        empty_s = 1'b1;
      end
    endcase
  end

  // State, pointers, count, checksum and registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_FILL;
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      drop_r      <= 1'b0;
      ovf_r       <= 1'b0;
      tx_enable_r <= 1'b0;
      last_data_r <= '0;
`ifdef MAPLE_TX_CKSUM_EN
      csum_r      <= '0;
`endif
    end else begin
      state_r     <= state_s;
      ovf_r       <= ovf_s;
      tx_enable_r <= tx_en_s;
      if (cap_s) begin
        last_data_r <= data_s;
      end
      if (clear_s) begin
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
        count_r  <= '0;
        drop_r   <= 1'b0;
`ifdef MAPLE_TX_CKSUM_EN
        csum_r   <= '0;
`endif
      end else begin
        if (store_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_ONE;
          count_r  <= count_r + CNT_ONE;
`ifdef MAPLE_TX_CKSUM_EN
          csum_r   <= maple_xor_acc(csum_r, wr_data);
`endif
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_ONE;
          count_r  <= count_r - CNT_ONE;
        end
        if (drop_set_s) begin
          drop_r <= 1'b1;
        end
      end
    end
  end

  assign wr_ready  = (state_r == ST_FILL) && (count_r < CNT_FULL);
  assign busy      = (state_r != ST_FILL);
  assign ovf       = ovf_r;
  assign tx_enable = tx_enable_r;
  assign data      = data_s;
  assign empty     = empty_s;

endmodule
